// File: rtl/logic_tile_pkg.sv
// Shared widths and configuration-chain layout for the LUT + switch-box tile.
// Constants and types only: no latency and no flow control.
package logic_tile_pkg;

    localparam int LUT_INPUTS  = 5;
    localparam int LUT_SIZE    = 32;
    localparam int SB_WIDTH    = 4;
    localparam int SB_CFG_W    = SB_WIDTH * SB_WIDTH;
    localparam int CFG_LEN     = 49;
    localparam int LUT_REG_SEL = 32;
    localparam int SB_CFG_LSB  = 33;

    // The field order matches the chain bit order: sb_cfg sits at the MSB end, next to cfg_out.
    typedef struct packed {
        logic [SB_CFG_W-1:0] sb_cfg;
        logic                reg_sel;
        logic [LUT_SIZE-1:0] truth;
    } cfg_t;

endpackage

// File: rtl/switch_box_4x4.sv
// 4x4 wired-OR crossbar: sb_out[i] is the OR of every sb_in[j] whose bit sb_cfg[4*i+j] is set.
// Purely combinational, so it has zero latency and no backpressure.
module switch_box_4x4
    import logic_tile_pkg::*;
(
    input  logic [SB_WIDTH-1:0] sb_in,
    input  logic [SB_CFG_W-1:0] sb_cfg,
    output logic [SB_WIDTH-1:0] sb_out
);

    always_comb begin
        sb_out = '0;
        for (int i = 0; i < SB_WIDTH; i++) begin
            for (int j = 0; j < SB_WIDTH; j++) begin
                sb_out[i] = sb_out[i] | (sb_in[j] & sb_cfg[i*SB_WIDTH+j]);
            end
        end
    end

endmodule

// File: rtl/logic_tile_sb.sv
// FPGA tile: a 5-LUT with an optional output flop, plus a 4x4 switch box, programmed by one 49-bit serial chain.
// out has 0 or 1 cycle of latency depending on reg_sel; sb_out has 0; there is no backpressure.
module logic_tile_sb
    import logic_tile_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                in1,
    input  logic                in2,
    input  logic                in3,
    input  logic                in4,
    input  logic                in5,
    output logic                out,
    input  logic [SB_WIDTH-1:0] sb_in,
    output logic [SB_WIDTH-1:0] sb_out,
    input  logic                cfg_en,
    input  logic                cfg_in,
    output logic                cfg_out
);

    cfg_t                  cfg_q, cfg_d;
    logic                  lut_q, lut_d;
    logic [LUT_INPUTS-1:0] lut_idx;
    logic                  lut_val;

    always_comb begin
        cfg_d = cfg_q;
        if (cfg_en) begin
            cfg_d = cfg_t'({cfg_q[CFG_LEN-2:0], cfg_in});
        end
    end

    assign lut_idx = {in5, in4, in3, in2, in1};
    assign lut_val = cfg_q.truth[lut_idx];
    // The output flop samples every cycle, so switching modes exposes a value that is already current.
    assign lut_d   = lut_val;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_q <= '0;
            lut_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            lut_q <= lut_d;
        end
    end

    assign out     = cfg_q.reg_sel ? lut_q : lut_val;
    assign cfg_out = cfg_q[CFG_LEN-1];

    switch_box_4x4 u_sb (
        .sb_in  (sb_in),
        .sb_cfg (cfg_q.sb_cfg),
        .sb_out (sb_out)
    );

endmodule

// File: tb/tb_logic_tile_sb.sv
// Self-checking bench for logic_tile_sb: expectations are pushed to a scoreboard queue when stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_logic_tile_sb;

    logic       clock;
    logic       reset;
    logic       in1, in2, in3, in4, in5;
    logic       out;
    logic [3:0] sb_in;
    logic [3:0] sb_out;
    logic       cfg_en;
    logic       cfg_in;
    logic       cfg_out;

    int   n_checks;
    int   n_fail;
    logic exp_q[$];
    logic [3:0] exp_sb_q[$];

    logic_tile_sb dut (
        .clock   (clock),
        .reset   (reset),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .in4     (in4),
        .in5     (in5),
        .out     (out),
        .sb_in   (sb_in),
        .sb_out  (sb_out),
        .cfg_en  (cfg_en),
        .cfg_in  (cfg_in),
        .cfg_out (cfg_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_idx(input logic [4:0] idx);
        {in5, in4, in3, in2, in1} = idx;
    endtask

    task automatic shift_bit(input logic b);
        cfg_en = 1'b1;
        cfg_in = b;
        @(posedge clock);
        #1;
        cfg_en = 1'b0;
    endtask

    task automatic load_cfg(input logic [48:0] word);
        for (int i = 48; i >= 0; i--) begin
            shift_bit(word[i]);
        end
    endtask

    task automatic test_reset;
        logic [4:0] r;
        r      = 5'($urandom);
        set_idx(r);
        sb_in  = 4'($urandom);
        cfg_in = 1'($urandom);
        cfg_en = 1'b0;
        reset  = 1'b1;
        #12;
        n_checks++;
        if (out !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b want 0", out); end
        n_checks++;
        if (sb_out !== 4'b0000) begin n_fail++; $display("FAIL reset_sb_out: got %b want 0000", sb_out); end
        n_checks++;
        if (cfg_out !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_out: got %b want 0", cfg_out); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cfg_in = 1'($urandom);
            sb_in  = 4'b1111;
            r      = 5'($urandom);
            set_idx(r);
            @(posedge clock);
            #1;
        end
        n_checks++;
        if ({out, sb_out, cfg_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got out=%b sb_out=%b cfg_out=%b want all 0", out, sb_out, cfg_out);
        end
    endtask

    task automatic test_comb_lut;
        logic [4:0] idx_tab[4] = '{5'd0, 5'd31, 5'd3, 5'd18};
        logic       exp_tab[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       e;
        load_cfg({16'h8421, 1'b0, 32'h8000_0001});
        for (int k = 0; k < 4; k++) begin
            set_idx(idx_tab[k]);
            exp_q.push_back(exp_tab[k]);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) begin n_fail++; $display("FAIL comb_lut idx=%0d: got %b want %b", idx_tab[k], out, e); end
        end
    endtask

    task automatic test_sb_identity;
        logic [3:0] in_tab[3] = '{4'b0001, 4'b0101, 4'b1111};
        logic [3:0] e;
        for (int k = 0; k < 3; k++) begin
            sb_in = in_tab[k];
            exp_sb_q.push_back(in_tab[k]);
            #1;
            e = exp_sb_q.pop_front();
            n_checks++;
            if (sb_out !== e) begin n_fail++; $display("FAIL sb_identity in=%b: got %b want %b", in_tab[k], sb_out, e); end
        end
    endtask

    task automatic test_sb_routing;
        logic [3:0] e;
        load_cfg({16'h000F, 1'b0, 32'h8000_0001});
        sb_in = 4'b0100;
        exp_sb_q.push_back(4'b0001);
        #1;
        e = exp_sb_q.pop_front();
        n_checks++;
        if (sb_out !== e) begin n_fail++; $display("FAIL sb_wired_or: got %b want %b", sb_out, e); end
        sb_in = 4'b1010;
        exp_sb_q.push_back(4'b0001);
        #1;
        e = exp_sb_q.pop_front();
        n_checks++;
        if (sb_out !== e) begin n_fail++; $display("FAIL sb_wired_or_multi: got %b want %b", sb_out, e); end
        load_cfg({16'h1248, 1'b0, 32'h8000_0001});
        sb_in = 4'b0001;
        exp_sb_q.push_back(4'b1000);
        #1;
        e = exp_sb_q.pop_front();
        n_checks++;
        if (sb_out !== e) begin n_fail++; $display("FAIL sb_reverse: got %b want %b", sb_out, e); end
        sb_in = 4'b0110;
        exp_sb_q.push_back(4'b0110);
        #1;
        e = exp_sb_q.pop_front();
        n_checks++;
        if (sb_out !== e) begin n_fail++; $display("FAIL sb_reverse_mid: got %b want %b", sb_out, e); end
    endtask

    task automatic test_registered;
        logic e;
        set_idx(5'd3);
        load_cfg({16'h8421, 1'b1, 32'h8000_0001});
        @(posedge clock);
        #1;
        n_checks++;
        if (out !== 1'b0) begin n_fail++; $display("FAIL reg_init: got %b want 0", out); end
        set_idx(5'd31);
        exp_q.push_back(1'b1);
        #2;
        n_checks++;
        if (out !== 1'b0) begin n_fail++; $display("FAIL reg_hold_old: got %b want 0", out); end
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) begin n_fail++; $display("FAIL reg_capture_ones: got %b want %b", out, e); end
        set_idx(5'd3);
        exp_q.push_back(1'b0);
        #2;
        n_checks++;
        if (out !== 1'b1) begin n_fail++; $display("FAIL reg_hold_one: got %b want 1", out); end
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) begin n_fail++; $display("FAIL reg_capture_idx3: got %b want %b", out, e); end
    endtask

    task automatic test_chain;
        logic [48:0] pat;
        logic        e;
        pat = {17'($urandom), 32'($urandom)};
        pat[48] = 1'b1;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 48; k++) exp_q.push_back(1'b0);
        for (int n = 0; n < 98; n++) begin
            if (n < 49) begin
                shift_bit(pat[48-n]);
                exp_q.push_back(pat[48-n]);
            end else begin
                shift_bit(1'($urandom));
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (cfg_out !== e) begin
                    n_fail++;
                    $display("FAIL chain_out shift=%0d: got %b want %b", n, cfg_out, e);
                end
            end
        end
        e = cfg_out;
        cfg_in = ~e;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (cfg_out !== e) begin n_fail++; $display("FAIL chain_hold: got %b want %b", cfg_out, e); end
    endtask

    task automatic test_reset_midshift;
        set_idx(5'd31);
        sb_in = 4'b1111;
        load_cfg({49{1'b1}});
        @(posedge clock);
        #1;
        n_checks++;
        if ({out, sb_out, cfg_out} !== 6'b111111) begin
            n_fail++;
            $display("FAIL midshift_pre: got out=%b sb_out=%b cfg_out=%b want all 1", out, sb_out, cfg_out);
        end
        cfg_en = 1'b1;
        cfg_in = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out, sb_out, cfg_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL midshift_reset: got out=%b sb_out=%b cfg_out=%b want all 0", out, sb_out, cfg_out);
        end
        @(posedge clock);
        #1;
        reset  = 1'b0;
        cfg_en = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({out, sb_out, cfg_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL midshift_after: got out=%b sb_out=%b cfg_out=%b want all 0", out, sb_out, cfg_out);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        cfg_en   = 1'b0;
        cfg_in   = 1'b0;
        sb_in    = 4'b0000;
        {in5, in4, in3, in2, in1} = 5'd0;
        test_reset;
        test_comb_lut;
        test_sb_identity;
        test_sb_routing;
        test_registered;
        test_chain;
        test_reset_midshift;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
